// File: rtl/rifl_tx_stats_if.sv
// Tap bundle for the TX statistics block: monitored link/stream/pause inputs,
// the snapshot request handshake and the snapshot/event outputs.
interface rifl_tx_stats_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 tx_up;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_last;
    logic                 tx_pause;
    logic                 tx_retrans;
    logic                 snap_req;
    logic                 snap_clear;
    logic                 tx_down_captured;
    logic                 tx_down_recovered;
    logic                 snap_valid;
    logic [CNT_WIDTH-1:0] frame_cnt;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] abort_cnt;
    logic [CNT_WIDTH-1:0] pause_evt_cnt;
    logic [CNT_WIDTH-1:0] pause_cyc_cnt;
    logic [CNT_WIDTH-1:0] retrans_cnt;
    logic [CNT_WIDTH-1:0] down_cnt;

    modport master (
        output tx_up, tx_valid, tx_ready, tx_last, tx_pause, tx_retrans,
               snap_req, snap_clear,
        input  tx_down_captured, tx_down_recovered, snap_valid,
               frame_cnt, beat_cnt, abort_cnt, pause_evt_cnt, pause_cyc_cnt,
               retrans_cnt, down_cnt
    );

    modport slave (
        input  tx_up, tx_valid, tx_ready, tx_last, tx_pause, tx_retrans,
               snap_req, snap_clear,
        output tx_down_captured, tx_down_recovered, snap_valid,
               frame_cnt, beat_cnt, abort_cnt, pause_evt_cnt, pause_cyc_cnt,
               retrans_cnt, down_cnt
    );
endinterface

// File: rtl/rifl_tx_stats.sv
// Transmit-side link statistics: passive event counters with registered event
// pulses and an atomic snapshot/clear readout path.
module rifl_tx_stats #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 1
) (
    input logic               clk,
    input logic               rst_n,
    rifl_tx_stats_if.slave    bus
);
    localparam int NUM_CNT = 7;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } link_state_t;

    link_state_t state_reg, state_next;
    logic        drop_evt, recover_evt;
    logic        in_frame_reg, in_frame_next;
    logic        pause_q_reg;
    logic        down_captured_reg, down_recovered_reg, snap_valid_reg;
    logic        beat, frame_done, clear_live;

    // Counter slots: frame, beat, abort, pause_evt, pause_cyc, retrans, down.
    logic [NUM_CNT-1:0]   evt;
    logic [CNT_WIDTH-1:0] live_reg [NUM_CNT];
    logic [CNT_WIDTH-1:0] live_inc [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_reg [NUM_CNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        drop_evt    = 1'b0;
        recover_evt = 1'b0;
        case (state_reg)
            ST_INIT: if (bus.tx_up) state_next = ST_UP;
            ST_UP: begin
                if (!bus.tx_up) begin
                    state_next = ST_DOWN;
                    drop_evt   = 1'b1;
                end
            end
            ST_DOWN: begin
                if (bus.tx_up) begin
                    state_next  = ST_UP;
                    recover_evt = 1'b1;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign beat       = bus.tx_valid & bus.tx_ready;
    assign frame_done = beat & bus.tx_last;
    assign clear_live = bus.snap_req & bus.snap_clear;

    // A last beat landing on the drop edge completes its frame rather than aborting it.
    assign evt[0] = frame_done;
    assign evt[1] = beat;
    assign evt[2] = drop_evt & in_frame_reg & ~frame_done;
    assign evt[3] = bus.tx_pause & ~pause_q_reg;
    assign evt[4] = bus.tx_pause;
    assign evt[5] = bus.tx_retrans;
    assign evt[6] = drop_evt;

    always_comb begin
        in_frame_next = in_frame_reg;
        if (drop_evt) begin
            in_frame_next = 1'b0;
        end else if (beat) begin
            in_frame_next = ~bus.tx_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame_reg       <= 1'b0;
            pause_q_reg        <= 1'b0;
            down_captured_reg  <= 1'b0;
            down_recovered_reg <= 1'b0;
            snap_valid_reg     <= 1'b0;
        end else begin
            in_frame_reg       <= in_frame_next;
            pause_q_reg        <= bus.tx_pause;
            down_captured_reg  <= drop_evt;
            down_recovered_reg <= recover_evt;
            snap_valid_reg     <= bus.snap_req;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            // Value including this edge's event; the snapshot captures it and a
            // clear restarts the live counter from just this edge's event.
            assign live_inc[gi] = !evt[gi]           ? live_reg[gi] :
                                  (&live_reg[gi])    ? ((SATURATE != 0) ? live_reg[gi] : '0) :
                                                       live_reg[gi] + CNT_ONE;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_reg[gi] <= '0;
                    snap_reg[gi] <= '0;
                end else begin
                    live_reg[gi] <= clear_live ? CNT_WIDTH'(evt[gi]) : live_inc[gi];
                    if (bus.snap_req) begin
                        snap_reg[gi] <= live_inc[gi];
                    end
                end
            end
        end
    endgenerate

    assign bus.tx_down_captured  = down_captured_reg;
    assign bus.tx_down_recovered = down_recovered_reg;
    assign bus.snap_valid        = snap_valid_reg;
    assign bus.frame_cnt         = snap_reg[0];
    assign bus.beat_cnt          = snap_reg[1];
    assign bus.abort_cnt         = snap_reg[2];
    assign bus.pause_evt_cnt     = snap_reg[3];
    assign bus.pause_cyc_cnt     = snap_reg[4];
    assign bus.retrans_cnt       = snap_reg[5];
    assign bus.down_cnt          = snap_reg[6];
endmodule

// File: doc/rifl_tx_stats.md
Name: rifl_tx_stats

Overview:
- Transmit-side link statistics block; the counterpart of the receive-side stats monitor.
- Passively taps the TX user stream handshake, the TX lane-up status, remote pause (flow control) and retransmission-start pulses.
- Maintains per-event counters, emits registered event pulses, and provides an atomic snapshot/clear handshake for software readout.
- Sits beside the TX framer; it never drives the data path.

Parameters:
- CNT_WIDTH, 32, width of every counter and snapshot register.
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to zero.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- tx_up  in  1  TX link up level
- tx_valid  in  1  user stream valid (monitored)
- tx_ready  in  1  user stream ready (monitored)
- tx_last  in  1  user stream last (monitored)
- tx_pause  in  1  remote flow-control pause level
- tx_retrans  in  1  single-cycle pulse: retransmission started
- snap_req  in  1  single-cycle snapshot request
- snap_clear  in  1  sampled with snap_req; 1 = clear live counters
- tx_down_captured  out  1  pulse: link dropped after init
- tx_down_recovered  out  1  pulse: link restored after drop
- snap_valid  out  1  pulse: snapshot registers updated
- frame_cnt  out  CNT_WIDTH  snapshot: completed frames
- beat_cnt  out  CNT_WIDTH  snapshot: accepted beats
- abort_cnt  out  CNT_WIDTH  snapshot: frames cut by link drop
- pause_evt_cnt  out  CNT_WIDTH  snapshot: pause rising edges
- pause_cyc_cnt  out  CNT_WIDTH  snapshot: cycles with tx_pause=1
- retrans_cnt  out  CNT_WIDTH  snapshot: tx_retrans pulses
- down_cnt  out  CNT_WIDTH  snapshot: link-drop events

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs, live counters, snapshot registers, in_frame, tx_up_q and tx_pause_q go to 0. Link FSM goes to INIT.
- Link FSM:
  - INIT -> UP when tx_up=1.
  - UP -> DOWN when tx_up=0.
  - DOWN -> UP when tx_up=1.
  - A tx_up drop while in INIT is not an event.
- Event pulses are registered, asserted for one cycle, one cycle after the sampling edge:
  - tx_down_captured on UP->DOWN.
  - tx_down_recovered on DOWN->UP.
  - Never asserted from INIT.
- Beat: cycle with tx_valid & tx_ready; increments live beat counter.
- in_frame:
  - Set on a beat with tx_last=0.
  - Cleared on a beat with tx_last=1; that beat also increments the frame counter.
  - A single-beat frame (last on first beat) counts 1 frame and never sets in_frame.
- Abort: on UP->DOWN with in_frame=1, abort counter +1, down counter +1 and in_frame cleared. Without in_frame, only the down counter increments.
  - A beat in the same cycle as the drop is still counted as a beat.
  - If that beat has tx_last=1, it completes the frame and is not an abort.
- Pause:
  - pause_cyc +1 every cycle tx_pause=1.
  - pause_evt +1 when tx_pause=1 and tx_pause_q=0.
  - Pause is counted regardless of link state.
- retrans +1 per cycle with tx_retrans=1.
- Arithmetic:
  - Each counter increments by at most 1 per cycle.
  - SATURATE=1: a counter at 2^CNT_WIDTH-1 holds.
  - SATURATE=0: a counter at 2^CNT_WIDTH-1 wraps to 0.
- Snapshot:
  - On snap_req=1 at edge N, all seven snapshot registers load live values that include every event sampled at edge N.
  - Snapshot outputs and snap_valid (one cycle) are visible after edge N.
  - If snap_clear=1, live counters restart at edge N: each counter becomes 1 if its event occurred at edge N, else 0. Events are neither lost nor double-counted across epochs.
  - snap_req on consecutive cycles gives back-to-back snapshots.
  - snap_clear is ignored without snap_req.
- Snapshot outputs change only on snap_req or reset; the live counters are not directly exposed.
- Reset mid-frame or mid-pause discards all state. After reset, the FSM is in INIT, so the first tx_up is not a recovery.

Test Plan:
- Reset, raise tx_up, send 3 frames of 4 beats each, then snap_req -> frame_cnt=3, beat_cnt=12, abort_cnt=0, down_cnt=0, snap_valid high 1 cycle; no down/recovered pulses.
- Drop tx_up after 2 beats of a frame, restore 5 cycles later, then snap_req -> abort_cnt=1, down_cnt=1; tx_down_captured 1 cycle after the drop; tx_down_recovered 1 cycle after the restore.
- Pause high for 7 cycles, low, then high for 3 cycles; also pulse tx_retrans twice; then snap_req -> pause_evt_cnt=2, pause_cyc_cnt=10, retrans_cnt=2.
- snap_req with snap_clear=1 coinciding with a tx_last beat, then snap_req with snap_clear=0 -> first snapshot includes the frame; second snapshot frame_cnt=1 and beat_cnt=1 (the same-edge beat only).
- CNT_WIDTH=4: send 20 single-beat frames. SATURATE=1 -> frame_cnt=15. SATURATE=0 -> frame_cnt=4.
- Assert rst_n=0 asynchronously mid-frame, between clock edges -> all outputs 0 immediately. Then raise tx_up -> no tx_down_recovered pulse.
